// File: rtl/ppr_pkg.sv
// ppr_pkg: shared state encoding and BRAM table layout for the
// personalized-PageRank random-walk engine and its score accumulator.
package ppr_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_CLEAR,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    // Word addresses of the two tables in the shared BRAM.
    localparam int COUNT_BASE = 100;
    localparam int SCORE_BASE = 1000;

    localparam int DEF_SEED_NUM  = 4;
    localparam int DEF_NODE_NUM  = 16;
    localparam int DEF_MAX_STEPS = 7;

    // Counter table is node-major: [node][seed-1][step].
    localparam int STEP_STRIDE  = 1;
    localparam int SEED_STRIDE  = DEF_MAX_STEPS;
    localparam int NODE_STRIDE  = DEF_MAX_STEPS * DEF_SEED_NUM;
    // Score table is seed-major: [seed-1][node].
    localparam int SCORE_STRIDE = DEF_NODE_NUM;

    function automatic int node_stride(int max_steps, int seed_num);
        return max_steps * seed_num;
    endfunction

endpackage

// File: rtl/ppr_addr_gen.sv
// ppr_addr_gen: seed/node/step sweep counters producing counter and score
// addresses by stride addition.
// Ports: clk, rst_n; init (restart at seed 1, node 0, step 0), step_inc
// (next step), pair_inc (next pair); count_addr, score_addr; last_step,
// last_node, last_seed flags for the current indices.
module ppr_addr_gen
    import ppr_pkg::*;
#(
    parameter int ADDR_WIDTH = 13,
    parameter int SEED_NUM   = DEF_SEED_NUM,
    parameter int NODE_NUM   = DEF_NODE_NUM,
    parameter int MAX_STEPS  = DEF_MAX_STEPS,
    parameter int CNT_BASE   = COUNT_BASE,
    parameter int SCR_BASE   = SCORE_BASE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  init,
    input  logic                  step_inc,
    input  logic                  pair_inc,
    output logic [ADDR_WIDTH-1:0] count_addr,
    output logic [ADDR_WIDTH-1:0] score_addr,
    output logic                  last_step,
    output logic                  last_node,
    output logic                  last_seed
);

    localparam int SCW = (SEED_NUM > 1) ? $clog2(SEED_NUM) : 1;
    localparam int NCW = (NODE_NUM > 1) ? $clog2(NODE_NUM) : 1;
    localparam int STW = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;

    localparam logic [ADDR_WIDTH-1:0] C0   = ADDR_WIDTH'(CNT_BASE);
    localparam logic [ADDR_WIDTH-1:0] S0   = ADDR_WIDTH'(SCR_BASE);
    localparam logic [ADDR_WIDTH-1:0] NSTR =
        ADDR_WIDTH'(node_stride(MAX_STEPS, SEED_NUM));
    localparam logic [ADDR_WIDTH-1:0] SSTR = ADDR_WIDTH'(MAX_STEPS);
    localparam logic [ADDR_WIDTH-1:0] AONE = ADDR_WIDTH'(1);

    logic [SCW-1:0]        seed_q;
    logic [NCW-1:0]        node_q;
    logic [STW-1:0]        step_q;
    logic [ADDR_WIDTH-1:0] seed_base_q;
    logic [ADDR_WIDTH-1:0] pair_base_q;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0] score_q;
    logic [ADDR_WIDTH-1:0] next_pair;
    logic [ADDR_WIDTH-1:0] next_seed;

    assign next_pair = pair_base_q + NSTR;
    assign next_seed = seed_base_q + SSTR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seed_q      <= '0;
            node_q      <= '0;
            step_q      <= '0;
            seed_base_q <= C0;
            pair_base_q <= C0;
            count_q     <= C0;
            score_q     <= S0;
        end else if (init) begin
            seed_q      <= '0;
            node_q      <= '0;
            step_q      <= '0;
            seed_base_q <= C0;
            pair_base_q <= C0;
            count_q     <= C0;
            score_q     <= S0;
        end else if (pair_inc) begin
            step_q  <= '0;
            // Score table is walked in sweep order, so it just counts up.
            score_q <= score_q + AONE;
            if (last_node) begin
                node_q      <= '0;
                seed_q      <= seed_q + SCW'(1);
                seed_base_q <= next_seed;
                pair_base_q <= next_seed;
                count_q     <= next_seed;
            end else begin
                node_q      <= node_q + NCW'(1);
                pair_base_q <= next_pair;
                count_q     <= next_pair;
            end
        end else if (step_inc) begin
            step_q  <= step_q + STW'(1);
            count_q <= count_q + AONE;
        end
    end

    assign count_addr = count_q;
    assign score_addr = score_q;
    assign last_step  = (step_q == STW'(MAX_STEPS - 1));
    assign last_node  = (node_q == NCW'(NODE_NUM - 1));
    assign last_seed  = (seed_q == SCW'(SEED_NUM - 1));

endmodule

// File: rtl/ppr_score_accumulator.sv
// ppr_score_accumulator: sweeps the visit-counter table, sums the per-step
// counters of every (seed, node) pair with saturation, writes score table.
// Ports: clk, rst_n (async, active low); start (begin sweep), bus_grant
// (BRAM port ownership); busy, done (completion pulse); address, data_out,
// write_enable (BRAM side, high-Z while ungranted); data_in (read data,
// one cycle after address). Build option COUNTER_CLEAR_EN: zero each
// counter in the cycle after it is read.
module ppr_score_accumulator #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 32,
    parameter int SEED_NUM   = 4,
    parameter int NODE_NUM   = 16,
    parameter int MAX_STEPS  = 7,
    parameter int COUNT_BASE = ppr_pkg::COUNT_BASE,
    parameter int SCORE_BASE = ppr_pkg::SCORE_BASE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  bus_grant,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] data_in
);
    import ppr_pkg::*;

    if (COUNT_BASE + NODE_NUM * MAX_STEPS * SEED_NUM > SCORE_BASE ||
        SCORE_BASE + SEED_NUM * NODE_NUM > (1 << ADDR_WIDTH)) begin : g_bad
        $error("ppr_score_accumulator: table layout does not fit");
    end

    state_t state_q, state_d;

    logic                  init, step_inc, pair_inc;
    logic                  rd_issue, rd_valid_q, clear_acc;
    logic                  last_step, last_node, last_seed;
    logic [ADDR_WIDTH-1:0] count_addr, score_addr;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [DATA_WIDTH-1:0] bus_wdata;
    logic                  bus_we;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [DATA_WIDTH:0]   sum;

    ppr_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .SEED_NUM   (SEED_NUM),
        .NODE_NUM   (NODE_NUM),
        .MAX_STEPS  (MAX_STEPS),
        .CNT_BASE   (COUNT_BASE),
        .SCR_BASE   (SCORE_BASE)
    ) u_addr_gen (
        .clk        (clk),
        .rst_n      (rst_n),
        .init       (init),
        .step_inc   (step_inc),
        .pair_inc   (pair_inc),
        .count_addr (count_addr),
        .score_addr (score_addr),
        .last_step  (last_step),
        .last_node  (last_node),
        .last_seed  (last_seed)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Nothing advances without the grant, so each stall costs one cycle.
    always_comb begin
        state_d   = state_q;
        init      = 1'b0;
        step_inc  = 1'b0;
        pair_inc  = 1'b0;
        rd_issue  = 1'b0;
        clear_acc = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_we    = 1'b0;
        if (bus_grant) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        init    = 1'b1;
                        state_d = S_READ;
                    end
                end
                S_READ: begin
                    rd_issue = 1'b1;
                    bus_addr = count_addr;
`ifdef COUNTER_CLEAR_EN
                    state_d  = S_CLEAR;
`else
                    step_inc = !last_step;
                    state_d  = last_step ? S_DRAIN : S_READ;
`endif
                end
                S_CLEAR: begin
                    bus_addr = count_addr;
                    bus_we   = 1'b1;
                    step_inc = !last_step;
                    state_d  = last_step ? S_DRAIN : S_READ;
                end
                S_DRAIN: begin
                    state_d = S_WRITE;
                end
                S_WRITE: begin
                    bus_addr  = score_addr;
                    bus_wdata = acc_q;
                    bus_we    = 1'b1;
                    clear_acc = 1'b1;
                    pair_inc  = 1'b1;
                    state_d   = (last_node && last_seed) ? S_DONE : S_READ;
                end
                S_DONE: begin
                    if (start) begin
                        init    = 1'b1;
                        state_d = S_READ;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign sum = {1'b0, acc_q} + {1'b0, data_in};

    // Capture runs on the read pipeline, not the grant, so a read issued
    // just before the grant drops still lands in the accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            rd_valid_q <= rd_issue;
            if (clear_acc)       acc_q <= '0;
            else if (rd_valid_q) acc_q <= sum[DATA_WIDTH] ? '1 : sum[DATA_WIDTH-1:0];
        end
    end

    assign busy = (state_q == S_READ)  || (state_q == S_CLEAR) ||
                  (state_q == S_DRAIN) || (state_q == S_WRITE);
    assign done = (state_q == S_DONE);

    assign address      = bus_grant ? bus_addr  : 'z;
    assign data_out     = bus_grant ? bus_wdata : 'z;
    assign write_enable = bus_grant ? bus_we    : 1'bz;

endmodule

// File: tb/tb_ppr_score_accumulator.sv
// tb_ppr_score_accumulator: directed vectors against a BRAM model,
// plus hand-written stall and mid-sweep reset sequences.
module tb_ppr_score_accumulator;

    localparam int AW = 13;
    localparam int DW = 32;
    localparam int SN = 4;
    localparam int NN = 16;
    localparam int MS = 7;
    localparam int CB = 100;
    localparam int SB = 1000;
    localparam int STALL_AT = 40;

`ifdef COUNTER_CLEAR_EN
    localparam int LAT   = 1025;
    localparam int RST_W = 6;
`else
    localparam int LAT   = 577;
    localparam int RST_W = 11;
`endif

    localparam int P_STEP   = 0;
    localparam int P_SPARSE = 1;
    localparam int P_ONES   = 2;

    typedef struct {
        int          pat;
        int          stall_len;
        int          latency;
        int          hit_idx;
        logic [31:0] hit_val;
        logic [31:0] other_val;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          bus_grant;
    logic          busy;
    logic          done;
    logic [AW-1:0] address;
    logic [DW-1:0] data_out;
    logic          write_enable;
    logic [DW-1:0] data_in;

    logic [31:0] mem [0:8191];
    logic [31:0] rd;
    int          score_wr;
    logic        fill_req;
    int          fill_pat;

    int errors = 0;
    int checks = 0;

    vec_t vecs [4];

    always #5 clk = ~clk;

    ppr_score_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bus_grant    (bus_grant),
        .busy         (busy),
        .done         (done),
        .address      (address),
        .data_out     (data_out),
        .write_enable (write_enable),
        .data_in      (data_in)
    );

    function automatic logic [31:0] init_word(int pat, int a);
        int off, node, seed, step;
        if (a < CB || a >= CB + NN * SN * MS) return 32'hA5A5_A5A5;
        off  = a - CB;
        node = off / (SN * MS);
        seed = (off % (SN * MS)) / MS + 1;
        step = off % MS;
        if (pat == P_STEP) return 32'(step + 1);
        if (pat == P_ONES) return 32'hFFFF_FFFF;
        if (seed == 2 && node == 5) begin
            if (step == 2) return 32'd3;
            if (step == 6) return 32'd1;
        end
        return 32'd0;
    endfunction

    always @(posedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 8192; i++) mem[i] <= init_word(fill_pat, i);
            score_wr <= 0;
        end else if (bus_grant) begin
            if (write_enable === 1'b1) begin
                mem[address] <= data_out;
                if (int'(address) >= SB) score_wr <= score_wr + 1;
            end
            rd <= mem[address];
        end
    end

    assign data_in = rd;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fill(input int pat);
        fill_pat = pat;
        fill_req = 1'b1;
        @(posedge clk);
        #1 fill_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int cyc;
        bit seen;
        int nz;
        fill(v.pat);
        start = 1'b1;
        cyc   = 0;
        seen  = 1'b0;
        while (!seen && cyc < 3000) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) begin
                start = 1'b0;
                chk("busy_rise", 32'(busy), 32'd1);
                chk("first_addr", 32'(address), 32'(CB));
            end
            if (v.stall_len > 0 && cyc == STALL_AT) bus_grant = 1'b0;
            if (v.stall_len > 0 && cyc == STALL_AT + v.stall_len) bus_grant = 1'b1;
            #1;
            if (!bus_grant) begin
                chk("stall_we", 32'(write_enable === 1'b1), 32'd0);
                chk("stall_addr", 32'(address === {AW{1'bz}} || address === '0), 32'd1);
                chk("stall_busy", 32'(busy), 32'd1);
            end
            if (done) seen = 1'b1;
        end
        chk("done_seen", 32'(seen), 32'd1);
        chk("latency", 32'(cyc), 32'(v.latency));
        chk("busy_at_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1 chk("done_pulse", 32'(done), 32'd0);
        for (int i = 0; i < SN * NN; i++)
            chk("score", mem[SB + i], (i == v.hit_idx) ? v.hit_val : v.other_val);
`ifdef COUNTER_CLEAR_EN
        nz = 0;
        for (int a = CB; a < CB + NN * SN * MS; a++)
            if (mem[a] != 0) nz++;
        chk("counters_cleared", 32'(nz), 32'd0);
`else
        nz = 0;
        chk("counters_kept", mem[CB + 5 * SN * MS + MS + 2], init_word(v.pat, CB + 5 * SN * MS + MS + 2));
`endif
    endtask

    initial begin
        vecs[0] = '{P_STEP,   0,  LAT,      0, 32'd28,         32'd28};
        vecs[1] = '{P_SPARSE, 0,  LAT,      21, 32'd4,         32'd0};
        vecs[2] = '{P_ONES,   0,  LAT,      0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[3] = '{P_STEP,   10, LAT + 10, 0, 32'd28,         32'd28};

        rst_n     = 1'b0;
        start     = 1'b0;
        bus_grant = 1'b1;
        fill_req  = 1'b0;
        fill_pat  = P_STEP;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_we", 32'(write_enable), 32'd0);
        chk("rst_addr", 32'(address), 32'd0);
        chk("rst_data", data_out, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 4; k++) run_vec(vecs[k]);

        fill(P_STEP);
        start = 1'b1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_we", 32'(write_enable), 32'd0);
        chk("abort_addr", 32'(address), 32'd0);
        chk("partial_writes", 32'(score_wr), 32'(RST_W));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("no_writes_after_rst", 32'(score_wr), 32'(RST_W));
        chk("last_written", mem[SB + RST_W - 1], 32'd28);
        chk("left_unwritten", mem[SB + RST_W], 32'hA5A5_A5A5);
        chk("idle_after_rst", 32'(busy), 32'd0);

        run_vec(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
